// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and default widths for the D-cache store-buffer write port
package dcache_pkg;
  localparam int DC_ADDR_W = 8;
  localparam int DC_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, RD_OLD, WRITE, ACK} dc_wr_state_e;
  typedef struct packed {
    logic [DC_ADDR_W-1:0]   addr;
    logic [DC_DATA_W-1:0]   wdata;
    logic [DC_DATA_W/8-1:0] sel_byte;
  } stb_req_t;
endpackage

// File: rtl/dcache_byte_merge.sv
// dcache_byte_merge: per-byte select between the old word and new store data
module dcache_byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] sel,
  output logic [DATA_W-1:0]   merged
);
  for (genvar b = 0; b < DATA_W/8; b++) begin : g_byte
    assign merged[8*b+:8] = sel[b] ? new_word[8*b+:8] : old_word[8*b+:8];
  end
endmodule

// File: rtl/dcache_stb_wr_port.sv
// dcache_stb_wr_port: store-buffer drain responder with read-merge-write and one load port
// Optional DCACHE_WR_CNT_EN adds the dcache_wr_count committed-store counter.
module dcache_stb_wr_port
  import dcache_pkg::*;
#(
  parameter int ADDR_W = DC_ADDR_W,
  parameter int DATA_W = DC_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stb2dcache_req,
  input  logic [ADDR_W-1:0]   stb2dcache_addr,
  input  logic [DATA_W-1:0]   stb2dcache_wdata,
  input  logic [DATA_W/8-1:0] stb2dcache_sel_byte,
  output logic                dcache2stb_ack,
  input  logic                lsummu2dcache_rd_req,
  input  logic [ADDR_W-1:0]   lsummu2dcache_raddr,
  output logic [DATA_W-1:0]   dcache2lsummu_rdata,
`ifdef DCACHE_WR_CNT_EN
  output logic [15:0]         dcache_wr_count,
`endif
  output logic                dcache2lsummu_rvalid
);
  localparam int SEL_W = DATA_W/8;
  localparam int OFF_W = $clog2(SEL_W);
  localparam int IDX_W = ADDR_W-OFF_W;
  localparam int DEPTH = 2**IDX_W;
  dc_wr_state_e state, state_nxt;
  stb_req_t req_q;
  logic [DATA_W-1:0] old_q, merged;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0] sidx, ridx;
  logic ld_ok;
  assign sidx = req_q.addr[ADDR_W-1:OFF_W];
  assign ridx = lsummu2dcache_raddr[ADDR_W-1:OFF_W];
  // loads only use the array in cycles the store path leaves free
  assign ld_ok = lsummu2dcache_rd_req && (state == IDLE || state == ACK);
  assign dcache2stb_ack = state == ACK;
  always_comb begin
    state_nxt = IDLE;
    state_nxt = state == IDLE   ? (stb2dcache_req ? RD_OLD : IDLE) :
                state == RD_OLD ? WRITE :
                state == WRITE  ? ACK : IDLE;
  end
  dcache_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word(old_q),
    .new_word(req_q.wdata),
    .sel     (req_q.sel_byte),
    .merged  (merged)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      dcache2lsummu_rvalid <= 1'b0;
      dcache2lsummu_rdata  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state                <= state_nxt;
      dcache2lsummu_rvalid <= ld_ok;
      if (state == IDLE && stb2dcache_req)
        req_q <= '{addr: stb2dcache_addr, wdata: stb2dcache_wdata, sel_byte: stb2dcache_sel_byte};
      if (state == RD_OLD) old_q <= mem[sidx];
      if (state == WRITE) mem[sidx] <= merged;
      if (ld_ok) dcache2lsummu_rdata <= mem[ridx];
    end
  end
`ifdef DCACHE_WR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) dcache_wr_count <= '0;
    else if (state == ACK) dcache_wr_count <= dcache_wr_count + 16'd1;
  end
`endif
endmodule
